// File: rtl/matrix_scan_drv.sv
// Row-multiplexed LED matrix scanner with a double-buffered frame image.
// Define MATRIX_SCAN_PWM_EN to enable brightness-controlled column on-time within each row.
module matrix_scan_drv #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DWELL = 1024,
    parameter int BLANK = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 oe,
    input  logic [ROWS*COLS-1:0] data,
    input  logic                 load,
    input  logic [3:0]           brightness,
    output logic                 load_ack,
    output logic                 frame_start,
    output logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      column
);

    localparam int                IDX_W      = $clog2(ROWS);
    localparam logic [IDX_W-1:0]  LAST_ROW   = IDX_W'(ROWS - 1);
    localparam logic [15:0]       DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0]       BLANK_LAST = (BLANK > 0) ? 16'(BLANK - 1) : 16'd0;
    localparam logic [ROWS-1:0]   ROW_ONE    = {{(ROWS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [ROWS*COLS-1:0]   active_q, active_d;
    logic [ROWS*COLS-1:0]   pending_q, pending_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   load_ack_q, load_ack_d;
    logic                   frame_start_q, frame_start_d;
    logic [ROWS-1:0]        row_q, row_d;
    logic [COLS-1:0]        column_q, column_d;
    logic                   boundary;

`ifdef MATRIX_SCAN_PWM_EN
    logic [19:0]            on_prod;
    logic [15:0]            on_time;

    assign on_prod = ({16'd0, brightness} + 20'd1) * 20'(DWELL);
    assign on_time = 16'(on_prod >> 4);
`else
    logic                   unused_brightness;

    assign unused_brightness = ^brightness;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        active_d      = active_q;
        pending_d     = pending_q;
        pend_vld_d    = pend_vld_q;
        load_ack_d    = 1'b0;
        boundary      = 1'b0;

        if (!oe) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    boundary = 1'b1;
                    idx_d    = '0;
                    cnt_d    = '0;
                    state_d  = (BLANK == 0) ? S_DRIVE : S_BLANK;
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d   = '0;
                        state_d = (BLANK == 0) ? S_DRIVE : S_BLANK;
                        if (idx_q == LAST_ROW) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        frame_start_d = boundary;

        // The active image may only change while stopped or exactly on a frame boundary.
        if (!oe || boundary) begin
            if (load) begin
                active_d   = data;
                pend_vld_d = 1'b0;
                load_ack_d = 1'b1;
            end else if (boundary && pend_vld_q) begin
                active_d   = pending_q;
                pend_vld_d = 1'b0;
                load_ack_d = 1'b1;
            end
        end else if (load) begin
            pending_d  = data;
            pend_vld_d = 1'b1;
        end

        row_d    = '0;
        column_d = '0;
        if (state_d == S_DRIVE) begin
            row_d    = ROW_ONE << idx_d;
            column_d = COLS'(active_d >> (int'(idx_d) * COLS));
`ifdef MATRIX_SCAN_PWM_EN
            if (cnt_d >= on_time) begin
                column_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            active_q      <= '0;
            pend_vld_q    <= 1'b0;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            row_q         <= '0;
            column_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            active_q      <= active_d;
            pend_vld_q    <= pend_vld_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
            row_q         <= row_d;
            column_q      <= column_d;
        end
    end

    // Pending contents are only meaningful while pend_vld_q is set.
    always_ff @(posedge clock) begin
        pending_q <= pending_d;
    end

    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;
    assign row         = row_q;
    assign column      = column_q;

endmodule

// File: tb/tb_matrix_scan_drv.sv
// Scoreboard bench for matrix_scan_drv: a frame-position reference model predicts every output cycle.
// Handles both builds; the model follows MATRIX_SCAN_PWM_EN the same way the design does.
module tb_matrix_scan_drv;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int DWELL   = 4;
    localparam int BLANK   = 1;
    localparam int PER_ROW = BLANK + DWELL;
    localparam int PERIOD  = ROWS * PER_ROW;

    localparam logic [63:0] DIAG = 64'h8040201008040201;

    logic                 clock = 1'b0;
    logic                 resetn = 1'b1;
    logic                 oe = 1'b0;
    logic                 load = 1'b0;
    logic [ROWS*COLS-1:0] data = '0;
    logic [3:0]           brightness = 4'd0;
    logic                 load_ack;
    logic                 frame_start;
    logic [ROWS-1:0]      row;
    logic [COLS-1:0]      column;

    typedef struct packed {
        logic [ROWS-1:0] row;
        logic [COLS-1:0] col;
        logic            ack;
        logic            fs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: scan position within the frame plus the two image buffers.
    bit          m_run;
    int          m_pos;
    logic [63:0] m_act;
    logic [63:0] m_pend;
    bit          m_pv;

    matrix_scan_drv #(
        .ROWS (ROWS),
        .COLS (COLS),
        .DWELL(DWELL),
        .BLANK(BLANK)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .oe         (oe),
        .data       (data),
        .load       (load),
        .brightness (brightness),
        .load_ack   (load_ack),
        .frame_start(frame_start),
        .row        (row),
        .column     (column)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_pos  = 0;
        m_act  = '0;
        m_pend = '0;
        m_pv   = 1'b0;
    endtask

    task automatic model_step(input logic oe_i, input logic load_i, input logic [63:0] d,
                              input logic [3:0] br, output exp_t e);
        bit boundary;
        int r;
        int ph;
        e        = '0;
        boundary = 1'b0;
        if (!oe_i) begin
            m_run = 1'b0;
            m_pos = 0;
            if (load_i) begin
                m_act = d;
                m_pv  = 1'b0;
                e.ack = 1'b1;
            end
        end else begin
            if (!m_run) begin
                m_run    = 1'b1;
                m_pos    = 0;
                boundary = 1'b1;
            end else begin
                m_pos++;
                if (m_pos == PERIOD) begin
                    m_pos    = 0;
                    boundary = 1'b1;
                end
            end
            if (boundary) begin
                e.fs = 1'b1;
                if (load_i) begin
                    m_act = d;
                    m_pv  = 1'b0;
                    e.ack = 1'b1;
                end else if (m_pv) begin
                    m_act = m_pend;
                    m_pv  = 1'b0;
                    e.ack = 1'b1;
                end
            end else if (load_i) begin
                m_pend = d;
                m_pv   = 1'b1;
            end
        end
        if (m_run) begin
            r  = m_pos / PER_ROW;
            ph = (m_pos % PER_ROW) - BLANK;
            if (ph >= 0) begin
                e.row = ROWS'(1 << r);
                e.col = m_act[r*COLS +: COLS];
`ifdef MATRIX_SCAN_PWM_EN
                if (ph >= (((int'(br) + 1) * DWELL) >> 4)) e.col = '0;
`endif
            end
        end
    endtask

    task automatic step(input logic oe_i, input logic load_i, input logic [63:0] d, input logic [3:0] br);
        exp_t e;
        oe         = oe_i;
        load       = load_i;
        data       = d;
        brightness = br;
        @(posedge clock);
        model_step(oe_i, load_i, d, br, e);
        sb.push_back(e);
        #1;
    endtask

    task automatic run_until_row(input int r);
        int n;
        n = 0;
        while (!(m_run && (m_pos / PER_ROW) == r && (m_pos % PER_ROW) >= BLANK) && n < 2 * PERIOD) begin
            step(1'b1, 1'b0, '0, 4'd15);
            n++;
        end
        check($sformatf("reach_row%0d", r), 64'(n < 2 * PERIOD), 64'd1);
    endtask

    task automatic run_until_pos(input int p);
        int n;
        n = 0;
        while (!(m_run && m_pos == p) && n < 2 * PERIOD) begin
            step(1'b1, 1'b0, '0, 4'd15);
            n++;
        end
        check($sformatf("reach_pos%0d", p), 64'(n < 2 * PERIOD), 64'd1);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("row", 64'(row), 64'(e.row));
                check("column", 64'(column), 64'(e.col));
                check("load_ack", 64'(load_ack), 64'(e.ack));
                check("frame_start", 64'(frame_start), 64'(e.fs));
                check("row_onehot", 64'($countones(row) <= 1), 64'd1);
            end
        end
    end

    initial begin : driver
        model_reset();
        #1 resetn = 1'b0;
        #2;
        check("reset_row", 64'(row), 64'd0);
        check("reset_column", 64'(column), 64'd0);
        check("reset_load_ack", 64'(load_ack), 64'd0);
        check("reset_frame_start", 64'(frame_start), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #1 resetn = 1'b1;

        // Idle load swaps at once, then two full frames of the diagonal.
        step(1'b0, 1'b1, DIAG, 4'd15);
        repeat (2 * PERIOD + 2) step(1'b1, 1'b0, '0, 4'd15);

        // Mid-frame load waits for the wrap.
        run_until_row(3);
        step(1'b1, 1'b1, '1, 4'd15);
        repeat (PERIOD + 4) step(1'b1, 1'b0, '0, 4'd15);

        // Two loads in one frame: last one wins, one ack.
        run_until_row(1);
        step(1'b1, 1'b1, {8{8'hAA}}, 4'd15);
        run_until_row(4);
        step(1'b1, 1'b1, {8{8'h55}}, 4'd15);
        repeat (PERIOD + 4) step(1'b1, 1'b0, '0, 4'd15);

        // Drop oe during row 5, then restart from row 0.
        run_until_row(5);
        repeat (4) step(1'b0, 1'b0, '0, 4'd15);
        repeat (PERIOD + 2) step(1'b1, 1'b0, '0, 4'd15);

        // Load exactly on the wrap edge bypasses pending.
        run_until_pos(PERIOD - 1);
        step(1'b1, 1'b1, 64'h0123456789ABCDEF, 4'd15);
        repeat (PERIOD) step(1'b1, 1'b0, '0, 4'd15);

        // Pending survives oe low and lands at the restart.
        run_until_row(2);
        step(1'b1, 1'b1, 64'hF0E1D2C3B4A59687, 4'd15);
        repeat (3) step(1'b0, 1'b0, '0, 4'd15);
        repeat (PERIOD + 2) step(1'b1, 1'b0, '0, 4'd15);

        // Brightness codes (only change column timing in the PWM build).
        repeat (PERIOD) step(1'b1, 1'b0, '0, 4'd3);
        repeat (PERIOD) step(1'b1, 1'b0, '0, 4'd0);
        repeat (PERIOD) step(1'b1, 1'b0, '0, 4'd7);

        repeat (600) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 29) == 0),
                 {$urandom, $urandom}, 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset in the middle of a DRIVE cycle.
        step(1'b0, 1'b1, DIAG, 4'd15);
        run_until_row(6);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_row", 64'(row), 64'd0);
        check("async_rst_column", 64'(column), 64'd0);
        check("async_rst_load_ack", 64'(load_ack), 64'd0);
        check("async_rst_frame_start", 64'(frame_start), 64'd0);
        model_reset();
        @(posedge clock);
        #1 resetn = 1'b1;
        repeat (PERIOD + 2) step(1'b1, 1'b0, '0, 4'd15);
        step(1'b0, 1'b1, DIAG, 4'd15);
        repeat (PERIOD + 2) step(1'b1, 1'b0, '0, 4'd15);

        @(negedge clock);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_scan_drv.md
MATRIX_SCAN_DRV -- requirements
Module: matrix_scan_drv

Interface
REQ-001 Parameter ROWS, default 8: number of scanned rows, range 2..32.
REQ-002 Parameter COLS, default 8: columns per row, range 1..32.
REQ-003 Parameter DWELL, default 1024: clocks each row is driven, range 1..65535.
REQ-004 Parameter BLANK, default 4: all-off clocks before each row, range 0..255.
REQ-005 clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 oe  in  1  scan enable; low forces the idle state.
REQ-008 data  in  ROWS*COLS  frame image; row r occupies bits [r*COLS +: COLS].
REQ-009 load  in  1  one-clock strobe capturing data into the pending buffer.
REQ-010 brightness  in  4  PWM duty code; used only when MATRIX_SCAN_PWM_EN is defined.
REQ-011 load_ack  out  1  one-clock pulse when a frame becomes active.
REQ-012 frame_start  out  1  one-clock pulse on the first BLANK clock of row 0.
REQ-013 row  out  ROWS  one-hot row drive, registered.
REQ-014 column  out  COLS  column drive for the current row, registered.

Function
REQ-015 The block SHALL hold an active frame buffer, a pending frame buffer and a pending_valid flag.
REQ-016 The state machine SHALL have states IDLE, BLANK and DRIVE, plus a row index (0..ROWS-1) and a cycle counter.
REQ-017 IDLE: row=0, column=0; when oe is sampled high, go to BLANK with row index 0 (to DRIVE directly if BLANK=0), pulsing frame_start.
REQ-018 BLANK: row=0 and column=0 for exactly BLANK clocks, then go to DRIVE.
REQ-019 DRIVE: row = one-hot bit r and column = active[r*COLS +: COLS] for exactly DWELL clocks, then advance.
REQ-020 On advance, the row index SHALL increment; after ROWS-1 it SHALL wrap to 0 at a frame boundary, pulsing frame_start on the next clock.
REQ-021 Frame period SHALL be ROWS*(BLANK+DWELL) clocks, with no extra cycles at wrap.
REQ-022 load=1 SHALL copy data into pending and set pending_valid; a load while pending_valid is set overwrites pending (last wins).
REQ-023 At a frame boundary with pending_valid set, pending SHALL be copied to active, pending_valid cleared and load_ack pulsed on the same edge.
REQ-024 A load on the boundary edge itself SHALL bypass pending: data goes straight to active, load_ack pulses and pending_valid ends cleared.
REQ-025 Active contents SHALL never change mid-frame; row output changes only at BLANK/DRIVE transitions.
REQ-026 When oe falls in any state, outputs SHALL be 0 on the next clock, the state SHALL be IDLE and the row index 0.
REQ-027 pending, pending_valid and active SHALL be retained across oe low.
REQ-028 While oe is low, a load SHALL swap immediately into active with load_ack.
REQ-029 At most one row bit SHALL be high in any cycle.

Reset
REQ-030 resetn low SHALL asynchronously force IDLE, row index 0, counter 0, row=0, column=0, load_ack=0, frame_start=0, pending_valid=0 and active=0.
REQ-031 After resetn deasserts, the first scan SHALL begin on the first edge with oe sampled high.

Configuration
REQ-032 Macro MATRIX_SCAN_PWM_EN defined: within DRIVE, column SHALL be driven during the first ((brightness+1)*DWELL)>>4 clocks and be 0 for the rest; row stays asserted the whole DWELL.
REQ-033 With PWM enabled and that on-time computing to 0, column SHALL be 0 for the whole row.
REQ-034 Macro undefined: brightness is ignored and column is driven for the full DWELL; timing is otherwise identical.

Verification (ROWS=8, COLS=8, DWELL=4, BLANK=1)
REQ-035 Reset, load data=64'h8040201008040201, raise oe -> load_ack immediately (idle swap); frame_start on first clock; rows 01,02..80 each 4 clocks after 1 blank clock; column equals row; period 40 clocks.
REQ-036 Mid-frame load of 64'hFF..FF during row 3 -> display unchanged until wrap; load_ack and the new image appear with frame_start.
REQ-037 Two loads in one frame (AA.., then 55..) -> only 55.. displayed at the next frame; a single load_ack.
REQ-038 Drop oe during DRIVE of row 5 -> row=0 and column=0 next clock; re-raise oe -> restart at row 0 with frame_start.
REQ-039 Assert resetn low mid-DRIVE, asynchronously off-edge -> outputs 0 before the next clock edge; active cleared.
REQ-040 PWM build, DWELL=16, brightness=3 -> column high 4 clocks then 0 for 12 clocks per row; brightness=15 -> 16 clocks; non-PWM build -> 16 clocks regardless.
